dec_unbinder_stream: RTL and testbench

//  Inverse of the encoder binder packs. Takes one bound (circularly shifted) sparse

---
 rtl/dec_unbinder_stream_if.sv | 38 +++
 rtl/dec_unbinder_stream.sv | 125 ++++++++++++
 tb/tb_dec_unbinder_stream.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dec_unbinder_stream_if.sv
// Stream interface for dec_unbinder_stream: request side plus the recovered-HV beat stream.
// The popcnt signal is present only when DEC_UNBIND_POPCNT_EN is defined.
interface dec_unbinder_stream_if #(
  parameter int HV_DIM = 256,
  parameter int IDX_W  = 5,
  parameter int PC_W   = 9
);
  logic              start_unbind;
  logic [HV_DIM-1:0] bound_hv;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [HV_DIM-1:0] recovered_hv;
  logic [IDX_W-1:0]  feat_idx;
  logic              out_last;
  logic              done;
`ifdef DEC_UNBIND_POPCNT_EN
  logic [PC_W-1:0]   popcnt;

  modport master (
    output start_unbind, bound_hv, out_ready,
    input  busy, out_valid, recovered_hv, feat_idx, out_last, done, popcnt
  );
  modport slave (
    input  start_unbind, bound_hv, out_ready,
    output busy, out_valid, recovered_hv, feat_idx, out_last, done, popcnt
  );
`else
  modport master (
    output start_unbind, bound_hv, out_ready,
    input  busy, out_valid, recovered_hv, feat_idx, out_last, done
  );
  modport slave (
    input  start_unbind, bound_hv, out_ready,
    output busy, out_valid, recovered_hv, feat_idx, out_last, done
  );
`endif
endinterface

// File: rtl/dec_unbinder_stream.sv
// Un-binds one captured HV against NUM_FEAT consecutive feature shifts, one beat per handshake.
// Optional popcount output enabled by DEC_UNBIND_POPCNT_EN.
package dec_unbinder_pkg;
  localparam int HV_DIM = 256;
  localparam int PC_W   = $clog2(HV_DIM) + 1;

  // Global feature shift table shared with the encoder binder.
  function automatic int unsigned shifts(input int unsigned i);
    case (i)
      380:     return 5;
      381:     return 0;
      382:     return 17;
      383:     return 255;
      384:     return 128;
      385:     return 300;
      386:     return 1;
      387:     return 64;
      388:     return 200;
      389:     return 511;
      default: return (i * 29 + 3) % 512;
    endcase
  endfunction
endpackage

module dec_unbinder_stream
  import dec_unbinder_pkg::*;
#(
  parameter int BASE_IDX = 380,
  parameter int NUM_FEAT = 10,
  parameter int IDX_W    = $clog2(NUM_FEAT) + 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  dec_unbinder_stream_if.slave bus,
  output logic [1:0]           state_dbg
);
  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready every beat output holds stable.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  cnt;
  logic [HV_DIM-1:0] cap_hv;
  logic [HV_DIM-1:0] rot [NUM_FEAT];
  logic [HV_DIM-1:0] rec_mux;

  // Each feature's rotation is fixed wiring; the counter only selects among them.
  for (genvar k = 0; k < NUM_FEAT; k++) begin : g_rot
    localparam int S = int'(shifts(BASE_IDX + k) % HV_DIM);
    if (S == 0) begin : g_pass
      assign rot[k] = cap_hv;
    end else begin : g_shift
      assign rot[k] = {cap_hv[S-1:0], cap_hv[HV_DIM-1:S]};
    end
  end

  always_comb begin
    rec_mux = '0;
    for (int k = 0; k < NUM_FEAT; k++) begin
      if (cnt == IDX_W'(k)) rec_mux = rot[k];
    end
  end

`ifdef DEC_UNBIND_POPCNT_EN
  logic [PC_W-1:0] pc_r;

  function automatic logic [PC_W-1:0] popcount(input logic [HV_DIM-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < HV_DIM; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  // Rotation preserves weight, so one count at capture serves every beat.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      pc_r <= '0;
    end else if (state == S_IDLE && bus.start_unbind) begin
      pc_r <= popcount(bus.bound_hv);
    end
  end

  assign bus.popcnt = pc_r;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      cap_hv <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_unbind) begin
            cap_hv <= bus.bound_hv;
            cnt    <= '0;
            state  <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            if (cnt == LAST_IDX) state <= S_DONE;
            else                 cnt   <= cnt + IDX_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = (state == S_EMIT);
  assign bus.out_valid    = (state == S_EMIT);
  assign bus.recovered_hv = rec_mux;
  assign bus.feat_idx     = cnt;
  assign bus.out_last     = (state == S_EMIT) && (cnt == LAST_IDX);
  assign bus.done         = (state == S_DONE);
  assign state_dbg        = state;
endmodule

// File: tb/tb_dec_unbinder_stream.sv
// Randomized scoreboard bench for dec_unbinder_stream with an index-level rotation model.
module tb_dec_unbinder_stream;
  import dec_unbinder_pkg::*;

  localparam int BASE_IDX = 380;
  localparam int NUM_FEAT = 10;
  localparam int IDX_W    = $clog2(NUM_FEAT) + 1;
  localparam int EW       = 1 + IDX_W + HV_DIM;
  localparam int CW       = 300;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [1:0] state_dbg;

  dec_unbinder_stream_if #(.HV_DIM(HV_DIM), .IDX_W(IDX_W), .PC_W(PC_W)) bus ();

  dec_unbinder_stream #(.BASE_IDX(BASE_IDX), .NUM_FEAT(NUM_FEAT), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [EW-1:0]   exp_q[$];
  logic [PC_W-1:0] pc_q[$];
  int checks = 0;
  int errors = 0;
  bit rand_mode = 1'b0;
  bit stall_en  = 1'b0;
  int stall_cnt = 0;
  bit pending_done = 1'b0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // reference model
  function automatic logic [HV_DIM-1:0] rand_hv();
    logic [HV_DIM-1:0] v;
    for (int i = 0; i < HV_DIM / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int shift_k(input int k);
    return int'(shifts(BASE_IDX + k) % HV_DIM);
  endfunction

  function automatic logic [HV_DIM-1:0] unbind_model(input logic [HV_DIM-1:0] hv, input int k);
    logic [HV_DIM-1:0] r;
    int s;
    s = shift_k(k);
    for (int j = 0; j < HV_DIM; j++) r[j] = hv[(j + s) % HV_DIM];
    return r;
  endfunction

  function automatic logic [HV_DIM-1:0] bind_model(input logic [HV_DIM-1:0] hv, input int k);
    logic [HV_DIM-1:0] b;
    int s;
    s = shift_k(k);
    for (int j = 0; j < HV_DIM; j++) b[(j + s) % HV_DIM] = hv[j];
    return b;
  endfunction

  function automatic logic [PC_W-1:0] ones_model(input logic [HV_DIM-1:0] hv);
    int n;
    n = 0;
    for (int j = 0; j < HV_DIM; j++) if (hv[j]) n++;
    return PC_W'(n);
  endfunction

  // driver tasks
  task automatic push_req(input logic [HV_DIM-1:0] hv, input int ovr_k, input logic [HV_DIM-1:0] ovr_hv);
    logic [HV_DIM-1:0] e;
    for (int k = 0; k < NUM_FEAT; k++) begin
      e = (k == ovr_k) ? ovr_hv : unbind_model(hv, k);
      exp_q.push_back({(k == NUM_FEAT - 1), IDX_W'(k), e});
      pc_q.push_back(ones_model(hv));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (state_dbg != 2'd0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", CW'(state_dbg), CW'(0));
  endtask

  task automatic start_req(input logic [HV_DIM-1:0] hv, input int done_at);
    wait_idle();
    bus.start_unbind = 1'b1;
    bus.bound_hv     = hv;
    @(posedge clk); #1;
    bus.start_unbind = 1'b0;
    bus.bound_hv     = rand_hv();
    check("first_valid", CW'({bus.out_valid, bus.feat_idx}), CW'({1'b1, IDX_W'(0)}));
    if (done_at > 0) begin
      repeat (done_at - 1) @(posedge clk);
      #1;
      check("done_time", CW'(bus.done), CW'(1));
    end
  endtask

  task automatic wait_beat(input int idx);
    int n;
    n = 0;
    while (!(bus.out_valid && bus.feat_idx == IDX_W'(idx)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_beat", CW'({bus.out_valid, bus.feat_idx}), CW'({1'b1, IDX_W'(idx)}));
  endtask

  // ready generator, updated just after each rising edge
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_en && bus.out_valid && bus.feat_idx == IDX_W'(4) && stall_cnt < 3) begin
        bus.out_ready = 1'b0;
        stall_cnt++;
      end else begin
        if (bus.out_valid && bus.feat_idx == IDX_W'(0)) stall_cnt = 0;
        bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        pending_done = 1'b0;
      end else begin
        if (pending_done) begin
          check("done_pulse", CW'(bus.done), CW'(1));
          pending_done = 1'b0;
        end else if (bus.done) begin
          check("unexpected_done", CW'(bus.done), CW'(0));
        end
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", CW'(bus.out_valid), CW'(0));
          end else begin
            e = exp_q[0];
            check("beat", CW'({bus.out_last, bus.feat_idx, bus.recovered_hv}), CW'(e));
`ifdef DEC_UNBIND_POPCNT_EN
            check("popcnt", CW'(bus.popcnt), CW'(pc_q[0]));
`endif
            if (bus.out_ready) begin
              void'(exp_q.pop_front());
              void'(pc_q.pop_front());
              if (e[EW-1]) pending_done = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [HV_DIM-1:0] h, h2, orig, t1;
    int n;
    bus.start_unbind = 1'b0;
    bus.bound_hv     = '0;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", CW'({bus.busy, bus.out_valid, bus.done, bus.out_last, bus.feat_idx, bus.recovered_hv}), CW'(0));
    check("reset_state", CW'(state_dbg), CW'(0));
`ifdef DEC_UNBIND_POPCNT_EN
    check("reset_popcnt", CW'(bus.popcnt), CW'(0));
`endif
    nrst = 1'b1;

    // single set bit, shift 5 lands at HV_DIM-5
    h = '0; h[0] = 1'b1;
    t1 = '0; t1[HV_DIM-5] = 1'b1;
    push_req(h, 0, t1);
    start_req(h, NUM_FEAT + 1);

    // encoder round trip for every feature position
    for (int k = 0; k < NUM_FEAT; k++) begin
      orig = rand_hv();
      h = bind_model(orig, k);
      push_req(h, k, orig);
      start_req(h, NUM_FEAT + 1);
    end

    // three-cycle stall on beat 4
    stall_en = 1'b1;
    h = rand_hv();
    push_req(h, -1, '0);
    start_req(h, NUM_FEAT + 1 + 3);
    stall_en = 1'b0;

    // start during beat 6 must be ignored
    h = rand_hv();
    h2 = ~h;
    push_req(h, -1, '0);
    start_req(h, 0);
    wait_beat(6);
    bus.start_unbind = 1'b1;
    bus.bound_hv     = h2;
    @(posedge clk); #1;
    bus.start_unbind = 1'b0;

    // reset mid-request during beat 5
    h = rand_hv();
    push_req(h, -1, '0);
    start_req(h, 0);
    wait_beat(5);
    nrst = 1'b0;
    @(posedge clk); #1;
    check("midreset_outputs", CW'({bus.busy, bus.out_valid, bus.done, bus.out_last, bus.feat_idx, bus.recovered_hv}), CW'(0));
    check("midreset_state", CW'(state_dbg), CW'(0));
`ifdef DEC_UNBIND_POPCNT_EN
    check("midreset_popcnt", CW'(bus.popcnt), CW'(0));
`endif
    nrst = 1'b1;
    exp_q.delete();
    pc_q.delete();
    repeat (NUM_FEAT + 2) begin
      @(posedge clk); #1;
      check("no_done_after_reset", CW'({bus.done, bus.out_valid}), CW'(0));
    end
    h = rand_hv();
    push_req(h, -1, '0);
    start_req(h, NUM_FEAT + 1);

`ifdef DEC_UNBIND_POPCNT_EN
    // sparse HV with 37 ones
    h = '0;
    for (int i = 0; i < 37; i++) h[i*7] = 1'b1;
    push_req(h, -1, '0);
    start_req(h, NUM_FEAT + 1);
`endif

    // random backpressure, back-to-back requests
    rand_mode = 1'b1;
    for (int r = 0; r < 8; r++) begin
      h = rand_hv();
      push_req(h, -1, '0);
      start_req(h, 0);
    end

    n = 0;
    while ((exp_q.size() != 0 || state_dbg != 2'd0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", CW'(exp_q.size()), CW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
